// File: rtl/ej32_pkg.sv
// Shared types, opcode constants and opcode-decode helpers for the eJ32 sequencer.
package ej32_pkg;

  typedef enum logic [1:0] {U_AU, U_BR, U_LS} unit_t;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} seq_state_t;

  localparam logic [7:0] OP_NOP           = 8'h00;
  localparam logic [7:0] OP_BIPUSH        = 8'h10;
  localparam logic [7:0] OP_SIPUSH        = 8'h11;
  localparam logic [7:0] OP_ILOAD         = 8'h15;
  localparam logic [7:0] OP_ISTORE        = 8'h36;
  localparam logic [7:0] OP_IFEQ          = 8'h99;
  localparam logic [7:0] OP_IF_ACMPNE     = 8'ha6;
  localparam logic [7:0] OP_GOTO          = 8'ha7;
  localparam logic [7:0] OP_JSR           = 8'ha8;
  localparam logic [7:0] OP_RET           = 8'ha9;
  localparam logic [7:0] OP_JRETURN       = 8'hb1;
  localparam logic [7:0] OP_INVOKEVIRTUAL = 8'hb6;
  localparam logic [7:0] OP_DONEXT        = 8'hca;
  localparam logic [7:0] OP_IMPDEP2       = 8'hff;

  function automatic logic is_if_op(input logic [7:0] c);
    return (c >= OP_IFEQ) && (c <= OP_IF_ACMPNE);
  endfunction

  function automatic unit_t op_unit(input logic [7:0] c);
    if (is_if_op(c)) return U_BR;
    case (c)
      OP_GOTO, OP_JSR, OP_RET, OP_JRETURN, OP_INVOKEVIRTUAL, OP_DONEXT: return U_BR;
      OP_ILOAD, OP_ISTORE: return U_LS;
      default: return U_AU;
    endcase
  endfunction

  function automatic logic [2:0] op_bytes(input logic [7:0] c);
    if (is_if_op(c)) return 3'd2;
    case (c)
      OP_BIPUSH, OP_ILOAD, OP_ISTORE, OP_RET, OP_JRETURN: return 3'd1;
      OP_SIPUSH, OP_GOTO, OP_INVOKEVIRTUAL, OP_DONEXT:    return 3'd2;
      OP_JSR:                                             return 3'd3;
      default:                                            return 3'd0;
    endcase
  endfunction

  // Branch-class ops spend one extra settle phase after their operands.
  function automatic logic [2:0] op_len(input logic [7:0] c, input int max_ph);
    logic [3:0] n;
    n = {1'b0, op_bytes(c)} + ((op_unit(c) == U_BR) ? 4'd1 : 4'd1 - 4'd1) + ((op_bytes(c) == 3'd0 && op_unit(c) != U_BR) ? 4'd1 : 4'd0);
    if (op_unit(c) != U_BR && op_bytes(c) != 3'd0) n = {1'b0, op_bytes(c)} + 4'd1;
    if (n > 4'(max_ph)) n = 4'(max_ph);
    return n[2:0];
  endfunction

endpackage

// File: rtl/ej32_tos_arb.sv
// Priority select (br > ls > au) of the TOS write-back candidates, with collision flag.
module ej32_tos_arb #(
  parameter int DSZ = 32
) (
  input  logic [DSZ-1:0] br_t,
  input  logic           br_t_x,
  input  logic [DSZ-1:0] ls_t,
  input  logic           ls_t_x,
  input  logic [DSZ-1:0] au_t,
  input  logic           au_t_x,
  output logic [DSZ-1:0] t_sel,
  output logic           t_we,
  output logic           t_coll
);

  always_comb begin
    t_sel = au_t;
    if (br_t_x)      t_sel = br_t;
    else if (ls_t_x) t_sel = ls_t;
  end

  assign t_we   = br_t_x | ls_t_x | au_t_x;
  assign t_coll = (br_t_x & ls_t_x) | (br_t_x & au_t_x) | (ls_t_x & au_t_x);

endmodule

// File: rtl/ej32_seq.sv
// eJ32 instruction sequencer: opcode fetch, phase stepping, unit enables and TOS write-back.
// state | meaning
// IDLE  | waiting for run
// FETCH | reading the opcode byte at p
// EXEC  | stepping phases of the current opcode, one unit enabled
// HALT  | impdep2 seen, held until reset
module ej32_seq
  import ej32_pkg::*;
#(
  parameter int ASZ     = 17,
  parameter int DSZ     = 32,
  parameter int MAX_PH  = 4,
  parameter int RESET_P = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           mem_rdy,
  input  logic [7:0]     ram_d,
  input  logic [ASZ-1:0] br_p,
  input  logic           br_psel,
  input  logic [DSZ-1:0] br_t,
  input  logic [DSZ-1:0] au_t,
  input  logic [DSZ-1:0] ls_t,
  input  logic           br_t_x,
  input  logic           au_t_x,
  input  logic           ls_t_x,
  output logic [7:0]     code,
  output logic [2:0]     phase,
  output logic [ASZ-1:0] p,
  output logic           fetch,
  output logic           br_en,
  output logic           au_en,
  output logic           ls_en,
  output logic [DSZ-1:0] t,
  output logic           halt,
  output logic           err_t
);

  seq_state_t     state, state_nx;
  unit_t          cur_unit;
  logic [2:0]     cur_len;
  logic [2:0]     cur_bytes;
  logic           last_ph;
  logic           arb_en;
  logic [DSZ-1:0] t_sel;
  logic           t_we;
  logic           t_coll;

  assign cur_unit  = op_unit(code);
  assign cur_len   = op_len(code, MAX_PH);
  assign cur_bytes = op_bytes(code);
  assign last_ph   = (phase == cur_len - 3'd1);
  assign arb_en    = (state == EXEC) && mem_rdy;

  ej32_tos_arb #(.DSZ(DSZ)) u_tos_arb (
    .br_t   (br_t),
    .br_t_x (br_t_x),
    .ls_t   (ls_t),
    .ls_t_x (ls_t_x),
    .au_t   (au_t),
    .au_t_x (au_t_x),
    .t_sel  (t_sel),
    .t_we   (t_we),
    .t_coll (t_coll)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fetch    = 1'b0;
    br_en    = 1'b0;
    au_en    = 1'b0;
    ls_en    = 1'b0;
    halt     = 1'b0;
    case (state)
      IDLE:  if (run) state_nx = FETCH;
      FETCH: begin
        fetch = 1'b1;
        if (!run)        state_nx = IDLE;
        else if (mem_rdy) state_nx = (ram_d == OP_IMPDEP2) ? HALT : EXEC;
      end
      EXEC: begin
        if (mem_rdy) begin
          case (cur_unit)
            U_BR:    br_en = 1'b1;
            U_LS:    ls_en = 1'b1;
            default: au_en = 1'b1;
          endcase
          if (last_ph) state_nx = FETCH;
        end
      end
      HALT:    halt = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code  <= OP_NOP;
      phase <= 3'd0;
      p     <= ASZ'(RESET_P);
      t     <= '0;
      err_t <= 1'b0;
    end else begin
      if (state == FETCH && run && mem_rdy) begin
        code  <= ram_d;
        p     <= p + 1'b1;
        phase <= 3'd0;
      end
      if (state == EXEC && mem_rdy) begin
        if (!last_ph) phase <= phase + 3'd1;
        // The settle phase lets the branching unit redirect p.
        if (cur_unit == U_BR && last_ph && br_psel) p <= br_p;
        else if (phase < cur_bytes)                 p <= p + 1'b1;
      end
      if (arb_en && t_we)   t     <= t_sel;
      if (arb_en && t_coll) err_t <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ej32_seq.sv
// Self-checking bench for ej32_seq: opcode vector table with event scoreboard, plus corner sequences.
module tb_ej32_seq;

  logic        clk;
  logic        rst;
  logic        run;
  logic        mem_rdy;
  logic [7:0]  ram_d;
  logic [16:0] br_p;
  logic        br_psel;
  logic [31:0] br_t, au_t, ls_t;
  logic        br_t_x, au_t_x, ls_t_x;
  logic [7:0]  code;
  logic [2:0]  phase;
  logic [16:0] p;
  logic        fetch, br_en, au_en, ls_en, halt, err_t;
  logic [31:0] t;

  logic [7:0]  mem [256];
  logic        cur_psel;
  logic [7:0]  cur_tgt;
  logic [2:0]  cur_last;
  logic        mon_on;
  int          n_tests, n_fail;

  typedef struct {
    logic        is_f;
    logic [16:0] p;
    logic [2:0]  ph;
    logic [2:0]  en;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [7:0] op;
    logic       psel;
    logic [7:0] tgt;
    logic [2:0] len;
    logic [2:0] en;
    logic [7:0] nxt;
  } vec_t;

  typedef struct {
    logic       bx, ax, lx;
    logic [7:0] exp_t;
    logic       exp_err;
  } tos_t;

  localparam logic [2:0] EN_BR = 3'b100, EN_AU = 3'b010, EN_LS = 3'b001;

  ej32_seq dut (
    .clk(clk), .rst(rst), .run(run), .mem_rdy(mem_rdy), .ram_d(ram_d),
    .br_p(br_p), .br_psel(br_psel),
    .br_t(br_t), .au_t(au_t), .ls_t(ls_t),
    .br_t_x(br_t_x), .au_t_x(au_t_x), .ls_t_x(ls_t_x),
    .code(code), .phase(phase), .p(p), .fetch(fetch),
    .br_en(br_en), .au_en(au_en), .ls_en(ls_en),
    .t(t), .halt(halt), .err_t(err_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and branching-unit models respond combinationally to the sequencer.
  assign ram_d   = mem[p[7:0]];
  assign br_p    = {9'd0, cur_tgt};
  assign br_psel = cur_psel & br_en & (phase == cur_last);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int j = 0; j < 256; j++) mem[j] = 8'h00;
  endtask

  task automatic run_prog(input int budget);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
    rst = 1'b0;
    mon_on = 1'b0;
    sb.delete();
    run = 1'b0;
    #1;
  endtask

  task automatic wait_en(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (br_en | au_en | ls_en) break;
    end
    chk("wait_en_timeout", 64'(k < budget), 64'd1);
  endtask

  vec_t vt[17];
  tos_t tt[8];

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; run = 1'b0; mem_rdy = 1'b1;
    br_t = 32'h11; au_t = 32'h22; ls_t = 32'h33;
    br_t_x = 1'b0; au_t_x = 1'b0; ls_t_x = 1'b0;
    cur_psel = 1'b0; cur_tgt = 8'h00; cur_last = 3'd0; mon_on = 1'b0;
    clear_mem();

    vt[0]  = '{8'h00, 1'b0, 8'h00, 3'd1, EN_AU, 8'h01};
    vt[1]  = '{8'ha7, 1'b1, 8'h10, 3'd3, EN_BR, 8'h10};
    vt[2]  = '{8'h99, 1'b0, 8'h20, 3'd3, EN_BR, 8'h03};
    vt[3]  = '{8'h99, 1'b1, 8'h20, 3'd3, EN_BR, 8'h20};
    vt[4]  = '{8'ha0, 1'b1, 8'h24, 3'd3, EN_BR, 8'h24};
    vt[5]  = '{8'ha8, 1'b1, 8'h30, 3'd4, EN_BR, 8'h30};
    vt[6]  = '{8'ha8, 1'b0, 8'h30, 3'd4, EN_BR, 8'h04};
    vt[7]  = '{8'ha9, 1'b1, 8'h40, 3'd2, EN_BR, 8'h40};
    vt[8]  = '{8'ha9, 1'b0, 8'h40, 3'd2, EN_BR, 8'h02};
    vt[9]  = '{8'h10, 1'b0, 8'h00, 3'd2, EN_AU, 8'h02};
    vt[10] = '{8'h11, 1'b0, 8'h00, 3'd3, EN_AU, 8'h03};
    vt[11] = '{8'h15, 1'b0, 8'h00, 3'd2, EN_LS, 8'h02};
    vt[12] = '{8'h36, 1'b0, 8'h00, 3'd2, EN_LS, 8'h02};
    vt[13] = '{8'h60, 1'b0, 8'h00, 3'd1, EN_AU, 8'h01};
    vt[14] = '{8'hfe, 1'b0, 8'h00, 3'd1, EN_AU, 8'h01};
    vt[15] = '{8'hb6, 1'b1, 8'h50, 3'd3, EN_BR, 8'h50};
    vt[16] = '{8'hb1, 1'b1, 8'h60, 3'd2, EN_BR, 8'h60};

    tt[0] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b1};
    tt[4] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1};
    tt[5] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
    tt[6] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    tt[7] = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b1};

    // Scoreboard monitor: every consumed fetch and every enabled EXEC cycle pops one event.
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (mon_on && rst && ((fetch && mem_rdy && run) || br_en || au_en || ls_en)) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected: got event at p=%0h phase=%0d, required none", p, phase);
          end else begin
            e = sb.pop_front();
            if (fetch) begin
              chk("sb_kind_fetch", 64'(e.is_f), 64'd1);
              chk("sb_fetch_p", 64'(p), 64'(e.p));
            end else begin
              chk("sb_kind_exec", 64'(e.is_f), 64'd0);
              chk("sb_phase", 64'(phase), 64'(e.ph));
              chk("sb_enables", 64'({br_en, au_en, ls_en}), 64'(e.en));
            end
          end
        end
      end
    join_none

    // Reset mid-instruction (goto in phase 1), checked before any clock edge.
    repeat (2) @(negedge clk);
    clear_mem(); mem[0] = 8'ha7;
    rst = 1'b1; run = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_phase", 64'(phase), 64'd1);
    rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({code, phase, p, fetch, br_en, au_en, ls_en, halt, err_t}), 64'd0);
    chk("reset_t", 64'(t), 64'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_cycle_fetch", 64'(fetch), 64'd1);
    rst = 1'b0; run = 1'b0;
    #1;

    // Opcode table through the scoreboard.
    for (int i = 0; i < 17; i++) begin
      clear_mem(); mem[0] = vt[i].op;
      cur_psel = vt[i].psel; cur_tgt = vt[i].tgt; cur_last = vt[i].len - 3'd1;
      sb.push_back('{1'b1, 17'd0, 3'd0, 3'd0});
      for (int ph = 0; ph < int'(vt[i].len); ph++) sb.push_back('{1'b0, 17'd0, 3'(ph), vt[i].en});
      sb.push_back('{1'b1, {9'd0, vt[i].nxt}, 3'd0, 3'd0});
      run_prog(40);
    end

    // Three back-to-back nops.
    clear_mem(); cur_psel = 1'b0; cur_last = 3'd0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b1, 17'(i), 3'd0, 3'd0});
      sb.push_back('{1'b0, 17'd0, 3'd0, EN_AU});
    end
    sb.push_back('{1'b1, 17'd3, 3'd0, 3'd0});
    run_prog(40);

    // ifeq not taken with a two-cycle memory stall in phase 1.
    clear_mem(); mem[0] = 8'h99;
    cur_psel = 1'b0; cur_tgt = 8'h44; cur_last = 3'd2;
    sb.push_back('{1'b1, 17'd0, 3'd0, 3'd0});
    for (int ph = 0; ph < 3; ph++) sb.push_back('{1'b0, 17'd0, 3'(ph), EN_BR});
    sb.push_back('{1'b1, 17'd3, 3'd0, 3'd0});
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk); #1;
        if (br_en && phase == 3'd1) break;
      end
      chk("stall_reach_ph1", 64'(k < 20), 64'd1);
    end
    mem_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("stall_hold", 64'({phase, p, br_en}), 64'({3'd1, 17'd2, 1'b0}));
    end
    mem_rdy = 1'b1;
    run_prog(20);

    // TOS arbitration: a strobe in FETCH is ignored, then a per-EXEC strobe table.
    clear_mem(); cur_psel = 1'b0;
    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk); #1;
        if (fetch) break;
      end
      chk("tos_reach_fetch", 64'(k < 10), 64'd1);
    end
    br_t_x = 1'b1; au_t_x = 1'b1;
    @(negedge clk); #1;
    br_t_x = 1'b0; au_t_x = 1'b0;
    chk("tos_ignored_outside_exec", 64'({t, err_t}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      wait_en(10);
      br_t_x = tt[i].bx; au_t_x = tt[i].ax; ls_t_x = tt[i].lx;
      @(negedge clk); #1;
      br_t_x = 1'b0; au_t_x = 1'b0; ls_t_x = 1'b0;
      chk("tos_t", 64'(t), 64'(tt[i].exp_t));
      chk("tos_err", 64'(err_t), 64'(tt[i].exp_err));
    end
    rst = 1'b0; run = 1'b0;
    #1;

    // impdep2 halts until reset.
    clear_mem(); mem[0] = 8'hff;
    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    begin
      int k;
      for (k = 0; k < 10; k++) begin
        @(negedge clk); #1;
        if (halt) break;
      end
      chk("halt_reached", 64'(k < 10), 64'd1);
    end
    chk("halt_p", 64'(p), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("halt_hold", 64'({halt, fetch, br_en, au_en, ls_en}), 64'(5'b10000));
    end
    rst = 1'b0;
    #1;
    chk("halt_reset", 64'({halt, p}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ej32_seq.md
Name: ej32_seq

Overview:
- Instruction sequencer and shared-bus controller for the eJ32 core.
- Fetches one opcode byte from memory, then steps the phase counter through each instruction's phases, consuming one operand byte per phase where needed.
- Enables exactly one execution unit per cycle: branching unit (br_en), arithmetic unit (au_en) or load/store unit (ls_en).
- Arbitrates the instruction pointer and TOS write-back returned by those units.

Parameters:
ASZ, 17, instruction address width
DSZ, 32, data/TOS width
MAX_PH, 4, maximum phases per instruction (phase width 3)
RESET_P, 0, instruction pointer after reset

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
run  in  1  start/continue execution
mem_rdy  in  1  memory byte valid this cycle; 0 stalls the sequencer
ram_d  in  8  byte from memory bus
br_p  in  ASZ  branch target from branching unit
br_psel  in  1  registered branch-taken select from branching unit
br_t, au_t, ls_t  in  DSZ  TOS candidates from each unit
br_t_x, au_t_x, ls_t_x  in  1  TOS write strobes
code  out  8  current opcode
phase  out  3  current phase
p  out  ASZ  instruction pointer / memory byte address
fetch  out  1  opcode fetch cycle
br_en, au_en, ls_en  out  1  unit enables
t  out  DSZ  arbitrated TOS register
halt  out  1  halted
err_t  out  1  sticky: multiple TOS strobes in one cycle

Behaviour:
- Reset (rst=0, asynchronous) gives these values:
  - state=IDLE, p=RESET_P, code=nop (0x00), phase=0, t=0;
  - all enables, fetch, halt and err_t = 0.
  - Reset mid-instruction aborts it immediately.
- IDLE:
  - run=1 moves to FETCH on the next edge.
- FETCH (fetch=1, enables=0):
  - mem_rdy=1: code<=ram_d, p<=p+1, phase<=0, go to EXEC.
  - If ram_d==0xff (impdep2): go to HALT instead.
  - run=0 sampled in FETCH moves to IDLE. An instruction is never abandoned because of run.
  - mem_rdy=0: hold.
- EXEC:
  - unit_en[op_unit(code)] = mem_rdy; all other enables 0.
  - mem_rdy=0 freezes p, phase, code and t.
  - With mem_rdy=1, if phase < op_bytes(code): p<=p+1, because the operand byte is consumed this cycle.
  - Settle phase: branch-class ops have op_len = op_bytes + 1 (goto/if*/donext/invokevirtual: 3; jsr: 4; ret/jreturn: 2).
    - In the final phase, br_en stays asserted so the branching unit clears its asel.
    - The sequencer samples br_psel: if 1, p<=br_p, overriding the increment.
  - phase==op_len(code)-1 with mem_rdy=1: go to FETCH. Otherwise phase<=phase+1.
  - op_len is clamped to MAX_PH. Unknown opcodes: op_len=1, op_bytes=0, unit=AU.
- HALT:
  - Held until reset. Enables 0, halt=1.
- p arithmetic wraps modulo 2^ASZ.
- TOS arbitration:
  - Only in EXEC with mem_rdy=1.
  - Priority br > ls > au; t<=winner on the edge.
  - No strobe: t holds.
  - Two or more strobes: winner still written, err_t<=1 (sticky until reset).
- A strobe outside EXEC is ignored and does not set err_t.

Decomposition:
- ej32_pkg:
  - unit_t enum {U_AU, U_BR, U_LS};
  - seq_state_t {IDLE, FETCH, EXEC, HALT};
  - functions op_len(code), op_bytes(code), op_unit(code), with the opcode constants already defined there.
- Sub-module ej32_tos_arb (combinational priority select plus collision detect):
  - inputs: three t/t_x pairs;
  - outputs: t_sel, t_we, t_coll.
- The sequencer holds the t and err_t flops.

Test Plan:
- Reset values: assert rst=0 mid-run. All outputs take reset values asynchronously, before the next clk edge; p=0. Release with run=1: fetch=1 on the first cycle.
- Three nops at 0..2, mem_rdy=1:
  - fetch/EXEC alternate;
  - au_en pulses once per nop;
  - p=1,2,3 after each FETCH.
- goto (0xa7, 0x00, 0x10) at p=0:
  - phases 0,1,2 with br_en=1;
  - bench drives br_psel=1, br_p=0x0010 in phase 2;
  - next FETCH at p=0x0010.
- ifeq not taken (br_psel=0 in settle):
  - next FETCH at p=3;
  - mem_rdy=0 for 2 cycles in phase 1 holds phase=1, p=2, br_en=0.
- TOS collision: br_t_x=1 (br_t=0x11) and au_t_x=1 (au_t=0x22) in the same EXEC cycle → t=0x11, err_t=1, and err_t stays 1 through subsequent instructions.
- Opcode 0xff → halt=1, enables stay 0 for 20 cycles; only rst=0 recovers.
